// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter for the RAM read/write data port.
// Port 0 is the CPU load/store path and port 1 is the I/O buffer-transfer engine.
// Each access follows the same sequence: grant in IDLE, one RAM cycle in ACCESS,
// and a one-cycle acknowledge in RESP.
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_last;
  logic              r_win;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rd;
  logic              r_e;

  logic              w_win;
  logic              w_take;
  logic              w_misalign;

  // On a tie, the port that did not win last time gets the grant.
  // With a single request, the requesting port wins.
  assign w_win      = (req == 2'b11) ? ~r_last : req[1];
  // A grant is never issued while reset is high, so no capture can be lost.
  assign w_take     = (r_state == S_IDLE) && (req != 2'b00) && !reset;
  assign w_misalign = (r_addr[2:0] != 3'b000);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: the access sequence is fixed at IDLE -> ACCESS -> RESP.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_take) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output logic: every output is zero except in the state that owns it.
  always_comb begin
    gnt       = 2'b00;
    ack       = 2'b00;
    rdata     = '0;
    err       = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (r_state)
      S_IDLE:   if (w_take) gnt[w_win] = 1'b1;
      S_ACCESS: begin
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        // A misaligned store must never reach RAM.
        mem_we    = r_we & ~w_misalign;
      end
      S_RESP:   begin
        ack[r_win] = 1'b1;
        rdata      = r_rd;
        err        = r_e;
      end
      default: ;
    endcase
  end

  // Capture the winning request at grant time, and capture the RAM result in ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last  <= 1'b1;
      r_win   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_e     <= 1'b0;
    end else begin
      if (w_take) begin
        r_win   <= w_win;
        r_last  <= w_win;
        r_we    <= w_win ? we[1] : we[0];
        r_addr  <= w_win ? addr1 : addr0;
        r_wdata <= w_win ? wdata1 : wdata0;
      end
      if (r_state == S_ACCESS) begin
        r_rd <= r_we ? '0 : mem_rdata;
        r_e  <= mem_err | w_misalign;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter.
// The stimulus queues the expected acknowledge for each access.
// A monitor pops that entry whenever the DUT raises ack.
// A small RAM model answers the rw port.
module tb_mem_port_arbiter;

  typedef struct {
    logic [1:0]  ack;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, we;
  logic [63:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  gnt, ack;
  logic [63:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        err, mem_we, mem_err;

  logic [63:0] ram [0:511] = '{default: '0};
  logic        pre_we;
  logic [8:0]  pre_idx;
  logic [63:0] pre_d;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   we_cnt  = 0;
  int   cyc     = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .ack(ack), .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  // RAM model: 4 KiB, combinational read, and rw_error for any address at or above 0x1000.
  assign mem_err   = |mem_addr[63:12];
  assign mem_rdata = mem_err ? 64'h0 : ram[mem_addr[11:3]];

  always @(posedge clk) begin
    if (pre_we) ram[pre_idx] <= pre_d;
    else if (mem_we && !mem_err) ram[mem_addr[11:3]] <= mem_wdata;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks ack against the scoreboard, counts RAM writes, and checks that gnt and ack never overlap.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_we) we_cnt++;
      if (gnt != 2'b00) chk("gnt_ack_overlap", {62'h0, ack}, 64'h0);
      if (ack != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", {62'h0, ack}, 64'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ack_port", {62'h0, ack}, {62'h0, e.ack});
          chk("ack_rdata", rdata, e.rdata);
          chk("ack_err", {63'h0, err}, {63'h0, e.err});
        end
      end
    end
  end

  // A single access: queue the expected response, request, then check the grant,
  // the RAM cycle and the ack timing. The task is entered just after a rising edge
  // and returns just after one, at the first IDLE cycle after the access.
  task automatic access(input int p, input bit w, input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] erd, input bit eerr, output int g);
    int n;
    logic [1:0] pm;
    pm = (p == 0) ? 2'b01 : 2'b10;
    exp_q.push_back('{ack: pm, rdata: erd, err: eerr});
    req[p] = 1'b1;
    we[p]  = w;
    if (p == 0) begin addr0 = a; wdata0 = wd; end
    else        begin addr1 = a; wdata1 = wd; end
    n = 0;
    @(negedge clk);
    while (gnt == 2'b00 && n < 20) begin @(negedge clk); n++; end
    g = cyc;
    chk("gnt_value", {62'h0, gnt}, {62'h0, pm});
    if (gnt == 2'b00) begin
      req[p] = 1'b0;
      void'(exp_q.pop_back());
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1 req[p] = 1'b0;
    @(negedge clk);
    chk("access_addr", mem_addr, a);
    chk("access_we", {63'h0, mem_we}, {63'h0, (w && a[2:0] == 3'b000)});
    @(negedge clk);
    chk("ack_timing", {62'h0, ack}, {62'h0, pm});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int g1, g2, wb, prev;
    logic [1:0] eg;
    reset = 1'b1; req = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    pre_we = 1'b1; pre_idx = 9'd8; pre_d = 64'hDEADBEEF_00000001;
    @(posedge clk); #1 pre_we = 1'b0;
    do_reset();

    // Check that every output is zero in reset/idle.
    @(negedge clk);
    chk("reset_outputs", {gnt, ack, err, mem_we, 58'h0} | rdata | mem_addr | mem_wdata, 64'h0);
    @(posedge clk); #1;

    // Single load on port 0.
    access(0, 1'b0, 64'h40, 64'h0, 64'hDEADBEEF_00000001, 1'b0, g1);

    // Store followed by a load on port 1, with exactly one write cycle and a three-cycle grant spacing.
    wb = we_cnt;
    access(1, 1'b1, 64'h80, 64'h1234, 64'h0, 1'b0, g1);
    access(1, 1'b0, 64'h80, 64'h0, 64'h1234, 1'b0, g2);
    chk("store_we_cycles", 64'(we_cnt - wb), 64'd1);
    chk("gnt_spacing", 64'(g2 - g1), 64'd3);

    // Simultaneous requests after reset; grants should alternate starting with port 0.
    do_reset();
    we = 2'b00; addr0 = 64'h40; addr1 = 64'h80;
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{ack: (i % 2 == 0) ? 2'b01 : 2'b10,
                        rdata: (i % 2 == 0) ? 64'hDEADBEEF_00000001 : 64'h1234, err: 1'b0});
    req = 2'b11;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      int n;
      n = 0;
      @(negedge clk);
      while (gnt == 2'b00 && n < 20) begin @(negedge clk); n++; end
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_gnt", {62'h0, gnt}, {62'h0, eg});
      if (i > 0) chk("rr_spacing", 64'(cyc - prev), 64'd3);
      prev = cyc;
    end
    @(posedge clk); #1 req = 2'b00;
    repeat (3) @(posedge clk); #1;

    // Misaligned store: RAM must not be written, the ack must report an error, and RAM[0x40] must be intact.
    wb = we_cnt;
    access(0, 1'b1, 64'h43, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, g1);
    chk("misalign_no_write", 64'(we_cnt - wb), 64'd0);
    access(0, 1'b0, 64'h40, 64'h0, 64'hDEADBEEF_00000001, 1'b0, g1);

    // Out-of-range load: RAM raises rw_error.
    access(1, 1'b0, 64'h2000, 64'h0, 64'h0, 1'b1, g1);

    // Reset during ACCESS: the pending ack is dropped and outputs are zero after the reset edge.
    req[0] = 1'b1; we[0] = 1'b0; addr0 = 64'h40;
    @(negedge clk);
    chk("rst_gnt", {62'h0, gnt}, 64'h1);
    @(posedge clk); #1 begin req[0] = 1'b0; reset = 1'b1; end
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_outputs", {gnt, ack, err, mem_we, 58'h0} | rdata | mem_addr | mem_wdata, 64'h0);
    @(posedge clk); #1 reset = 1'b0;
    g2 = cyc;
    access(0, 1'b0, 64'h40, 64'h0, 64'hDEADBEEF_00000001, 1'b0, g1);
    chk("rst_first_idle_gnt", 64'(g1 - g2), 64'd0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the RAM's single read/write data port between two requesters: port 0 is the CPU load/store path, port 1 is the I/O device's buffer-transfer engine. Each access is captured, presented to RAM for exactly one cycle, and answered with a one-cycle acknowledge carrying read data and error status. Selection is round-robin, so neither requester starves. The block sits between the control-unit/ALU address path, the io device, and the `ram` rw port; the instruction-fetch read port is untouched.

## Interface
- ADDR_W, 64, address width of both requesters and RAM rw port
- DATA_W, 64, data width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- req  in  2  per-port request; held with stable addr/we/wdata until gnt
- we  in  2  per-port write enable (1 = store, 0 = load)
- addr0, addr1  in  ADDR_W each  byte address per port
- wdata0, wdata1  in  DATA_W each  store data per port
- gnt  out  2  one-hot pulse, request captured this cycle
- ack  out  2  one-hot pulse, access complete
- rdata  out  DATA_W  load data, valid while any ack bit is high
- err  out  1  access error, valid while any ack bit is high
- mem_addr  out  ADDR_W  to ram rw_addr
- mem_wdata  out  DATA_W  to ram rw_data_in
- mem_we  out  1  to ram rw_write_en
- mem_rdata  in  DATA_W  from ram rw_data_out, combinational from mem_addr
- mem_err  in  1  from ram rw_error, combinational from mem_addr

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE, no req: stay in IDLE. All outputs stay 0.
- IDLE with req != 0: pick a winner.
  - If exactly one bit is set, that port wins.
  - If both bits are set, the port not in `last` wins.
  - Assert gnt[winner] this cycle.
  - Capture addr, we, wdata and winner into registers; set `last` = winner.
  - Go to ACCESS.
- Misalignment: a captured addr with addr[2:0] != 0 sets a `misalign` flag.
- ACCESS: drive mem_addr and mem_wdata from the captured registers.
  - mem_we = captured we and not misalign. A misaligned access never writes RAM.
  - At the end of the cycle, register rd = mem_rdata and e = mem_err | misalign.
  - For a write, rd is registered as 0.
  - Go to RESP.
- RESP: ack[winner] = 1, rdata = rd, err = e. Go to IDLE.
- Outside ACCESS: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Outside RESP: ack = 0, rdata = 0, err = 0.
- Requests arriving in ACCESS or RESP are ignored. The requester keeps req high and is served in the next IDLE.
- The loser of a simultaneous request is guaranteed the next grant.
- A requester deasserts req in the cycle after gnt. If req is still high in the next IDLE, it is treated as a new request.
- Reset values: FSM = IDLE, `last` = 1 (so port 0 wins the first tie), captured registers = 0, every output = 0.

## Timing
- Latency: gnt in cycle N, RAM access in cycle N+1, ack in cycle N+2.
- Throughput: at most one access every 3 cycles. The next gnt occurs no earlier than N+3.
- mem_we is high for exactly one cycle per granted aligned store.
- Reset asserted in any state: FSM returns to IDLE at that edge.
  - The pending ack is dropped.
  - mem_we is 0 in the cycle following the reset edge.
  - An ACCESS-cycle write that coincides with the reset edge has already been presented to RAM and is not undone.
- gnt and ack are never high in the same cycle.
- At most one bit of gnt is set; at most one bit of ack is set.

## Test plan
- Single load, port 0:
  - Stimulus: preload RAM[0x40] = 0xDEADBEEF_00000001; req = 01, we = 00, addr0 = 0x40 at cycle 0.
  - Required: gnt = 01 at cycle 0; mem_addr = 0x40 with mem_we = 0 at cycle 1; ack = 01 with rdata = 0xDEADBEEF_00000001 and err = 0 at cycle 2.
- Store then load, port 1:
  - Stimulus: store wdata1 = 0x1234 to addr1 = 0x80, then load 0x80.
  - Required: mem_we high for exactly one cycle; the load's ack = 10 with rdata = 0x1234; second gnt at cycle 3.
- Simultaneous requests after reset:
  - Stimulus: req = 11 held continuously.
  - Required: grants alternate 01, 10, 01, 10 at cycles 0, 3, 6, 9; no two gnt pulses are closer than 3 cycles.
- Misaligned store:
  - Stimulus: port 0 store to addr0 = 0x43.
  - Required: mem_we stays 0 throughout; ack = 01 with err = 1; RAM[0x40] is unchanged on a later load.
- Out-of-range address:
  - Stimulus: load from an address that makes RAM assert rw_error.
  - Required: ack with err = 1.
- Reset during ACCESS:
  - Stimulus: assert reset in cycle 1 of a load.
  - Required: no ack pulse; all outputs 0 the following cycle; a fresh req = 01 is granted 01 on the first IDLE cycle after reset deasserts.
